// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin arbitration, SETUP/ACCESS sequencing and a pready timeout.
// All outputs are registered; the fastest back-to-back rate is one transfer every 3 cycles.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_grant,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  win;
  logic [7:0]            cnt_inc;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    win = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    busy_d      = busy_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    grant_d     = 2'b00;
    rsp_vld_d   = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          state_d      = SETUP;
          owner_d      = win;
          last_d       = win;
          grant_d[win] = 1'b1;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          busy_d       = 1'b1;
          paddr_d      = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          pwrite_d     = req_write[win];
          if (req_write[win]) begin
            pwdata_d = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          end else begin
            pwdata_d = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = 8'd0;
      end

      ACCESS: begin
        // A pready on the final allowed cycle still completes normally.
        if (pready) begin
          state_d            = IDLE;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          busy_d             = 1'b0;
          rsp_vld_d[owner_q] = 1'b1;
          rsp_err_d          = 1'b0;
          rsp_rdata_d        = pwrite_q ? '0 : prdata;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_d            = IDLE;
          cnt_d              = cnt_inc;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          busy_d             = 1'b0;
          rsp_vld_d[owner_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_rdata_d        = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      busy_q      <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      grant_q     <= 2'b00;
      rsp_vld_q   <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      busy_q      <= busy_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      grant_q     <= grant_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_grant = grant_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transfer-timeline model checked every cycle plus directed literal checks.
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_write = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]    req_grant, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, busy, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b1;
  logic [DW-1:0] prdata = '0;

  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit armed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a transfer is described by how many cycles have passed since its grant.
  bit            m_on, m_last, m_own;
  int            m_t;
  logic [1:0]    e_grant, e_rsp;
  logic          e_psel, e_pen, e_pwrite, e_err;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rdata;

  always @(posedge pclk) begin
    cyc++;
    e_grant = 2'b00;
    e_rsp   = 2'b00;
    if (preset) begin
      armed = 1; m_on = 0; m_last = 1; m_own = 0; m_t = 0;
      e_psel = 0; e_pen = 0; e_pwrite = 0; e_err = 0;
      e_paddr = '0; e_pwdata = '0; e_rdata = '0;
    end else if (!m_on) begin
      if (req_valid != 2'b00) begin
        bit w;
        w = (req_valid == 2'b11) ? !m_last : req_valid[1];
        m_last = w; m_own = w; m_on = 1; m_t = 1;
        e_grant = w ? 2'b10 : 2'b01;
        e_psel = 1; e_pen = 0;
        e_paddr  = w ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        e_pwrite = req_write[w];
        e_pwdata = !req_write[w] ? '0 : (w ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0]);
      end
    end else begin
      if (m_t >= 2) begin
        if (pready) begin
          m_on = 0; e_err = 0; e_rdata = e_pwrite ? '0 : prdata;
        end else if (m_t - 1 == TO) begin
          m_on = 0; e_err = 1; e_rdata = '0;
        end
        if (!m_on) begin
          e_psel = 0; e_pen = 0;
          e_rsp = m_own ? 2'b10 : 2'b01;
        end
      end
      if (m_on) begin
        m_t++;
        e_pen = 1;
      end
    end
  end

  int            g_cyc[$], r_cyc[$], p_cyc[$], e_cyc[$];
  logic [1:0]    g_val[$], r_val[$];
  logic [DW-1:0] r_dat[$];
  logic          r_err[$];

  always @(negedge pclk) begin
    if (armed) begin
      chk("grant", 64'(req_grant), 64'(e_grant));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      chk("psel", 64'(psel), 64'(e_psel));
      chk("penable", 64'(penable), 64'(e_pen));
      chk("busy", 64'(busy), 64'(m_on));
      chk("pwrite", 64'(pwrite), 64'(e_pwrite));
      chk("paddr", 64'(paddr), 64'(e_paddr));
      chk("pwdata", 64'(pwdata), 64'(e_pwdata));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(e_err));
      if (req_grant != 2'b00) begin g_cyc.push_back(cyc); g_val.push_back(req_grant); end
      if (rsp_valid != 2'b00) begin
        r_cyc.push_back(cyc); r_val.push_back(rsp_valid);
        r_dat.push_back(rsp_rdata); r_err.push_back(rsp_err);
      end
      if (psel) p_cyc.push_back(cyc);
      if (penable) e_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic clr_logs();
    g_cyc.delete(); g_val.delete(); r_cyc.delete(); r_val.delete();
    r_dat.delete(); r_err.delete(); p_cyc.delete(); e_cyc.delete();
  endtask

  // Returns the cycle the grant appeared and which requester got it; drops that valid.
  task automatic wait_grant(input logic [1:0] m, output int gc, output logic [1:0] gv);
    gc = -1;
    gv = 2'b00;
    for (int i = 0; i < 12 && gc < 0; i++) begin
      tick();
      if ((req_grant & m) != 2'b00) begin
        gc = cyc;
        gv = req_grant;
        req_valid = req_valid & ~req_grant;
      end
    end
    chk("grant_seen", 64'(gc >= 0), 64'd1);
  endtask

  initial begin
    int t0, g, n;
    logic [1:0] gv;

    tick(); tick();
    preset = 1'b0;
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);

    // Tie fairness straight after reset.
    clr_logs();
    prdata = 32'h0000_1234; pready = 1'b1;
    req_addr = {32'h0000_0104, 32'h0000_0004};
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      tick();
      if (req_grant != 2'b00) n++;
    end
    req_valid = 2'b00;
    chk("tie_count", 64'(n), 64'd4);
    repeat (4) tick();
    chk("tie_ngrants", 64'(g_val.size()), 64'd4);
    if (g_val.size() == 4) begin
      chk("tie_order0", 64'(g_val[0]), 64'd1);
      chk("tie_order1", 64'(g_val[1]), 64'd2);
      chk("tie_order2", 64'(g_val[2]), 64'd1);
      chk("tie_order3", 64'(g_val[3]), 64'd2);
      for (int k = 0; k < 3; k++) chk("tie_spacing", 64'(g_cyc[k+1] - g_cyc[k]), 64'd3);
    end

    // Single read, zero wait states.
    clr_logs();
    prdata = 32'hCAFE_0001; pready = 1'b1;
    req_write = 2'b00; req_addr = {32'h0, 32'h0000_0010};
    t0 = cyc;
    req_valid = 2'b01;
    wait_grant(2'b01, g, gv);
    repeat (4) tick();
    chk("rd_grant_cyc", 64'(g), 64'(t0 + 1));
    chk("rd_npsel", 64'(p_cyc.size()), 64'd2);
    chk("rd_npen", 64'(e_cyc.size()), 64'd1);
    if (p_cyc.size() == 2) chk("rd_psel_first", 64'(p_cyc[0]), 64'(t0 + 1));
    if (e_cyc.size() == 1) chk("rd_pen_cyc", 64'(e_cyc[0]), 64'(t0 + 2));
    chk("rd_nrsp", 64'(r_cyc.size()), 64'd1);
    if (r_cyc.size() == 1) begin
      chk("rd_rsp_cyc", 64'(r_cyc[0]), 64'(t0 + 3));
      chk("rd_rsp_val", 64'(r_val[0]), 64'd1);
      chk("rd_rdata", 64'(r_dat[0]), 64'hCAFE_0001);
      chk("rd_err", 64'(r_err[0]), 64'd0);
    end

    // Write from requester 1 with three wait states.
    clr_logs();
    prdata = 32'hDEAD_DEAD; pready = 1'b0;
    req_write = 2'b10; req_addr = {32'h2000_0040, 32'h0};
    req_wdata = {32'h0000_55AA, 32'h1111_1111};
    req_valid = 2'b10;
    wait_grant(2'b10, g, gv);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) pready = 1'b1;
      chk("ws_pwdata", 64'(pwdata), 64'h55AA);
      chk("ws_paddr", 64'(paddr), 64'h2000_0040);
    end
    tick();
    chk("ws_rsp", 64'(rsp_valid), 64'd2);
    chk("ws_err", 64'(rsp_err), 64'd0);
    chk("ws_rdata", 64'(rsp_rdata), 64'd0);
    chk("ws_npen", 64'(e_cyc.size()), 64'd4);
    req_write = 2'b00;

    // Timeout abort, then a normal transfer.
    clr_logs();
    prdata = 32'h0000_BEEF; pready = 1'b0;
    req_addr = {32'h0000_0034, 32'h0000_0030};
    req_valid = 2'b01;
    wait_grant(2'b01, g, gv);
    repeat (4) tick();
    chk("to_no_early_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("to_rsp", 64'(rsp_valid), 64'd1);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_rdata", 64'(rsp_rdata), 64'd0);
    chk("to_psel", 64'(psel), 64'd0);
    chk("to_npen", 64'(e_cyc.size()), 64'd4);
    pready = 1'b1; prdata = 32'h0000_0077;
    req_valid = 2'b10;
    wait_grant(2'b10, g, gv);
    tick(); tick();
    chk("post_to_rsp", 64'(rsp_valid), 64'd2);
    chk("post_to_err", 64'(rsp_err), 64'd0);
    chk("post_to_rdata", 64'(rsp_rdata), 64'h77);

    // pready arriving on the last allowed ACCESS cycle.
    prdata = 32'h0000_0B0B; pready = 1'b0;
    req_valid = 2'b01;
    wait_grant(2'b01, g, gv);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) pready = 1'b1;
    end
    tick();
    chk("bnd_rsp", 64'(rsp_valid), 64'd1);
    chk("bnd_err", 64'(rsp_err), 64'd0);
    chk("bnd_rdata", 64'(rsp_rdata), 64'h0B0B);

    // Reset while in ACCESS: no response, pointer back to favour requester 0.
    pready = 1'b0;
    req_valid = 2'b01;
    wait_grant(2'b01, g, gv);
    tick();
    chk("rm_pen_before", 64'(penable), 64'd1);
    clr_logs();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    chk("rm_psel", 64'(psel), 64'd0);
    chk("rm_pen", 64'(penable), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("rm_no_rsp", 64'(r_cyc.size()), 64'd0);
    pready = 1'b1;
    req_valid = 2'b11;
    wait_grant(2'b11, g, gv);
    req_valid = 2'b00;
    chk("rm_tie_winner", 64'(gv), 64'd1);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of paddr and of each requester address.
REQ-002 Parameter DATA_WIDTH, default 32: width of pwdata, prdata, requester write data and response data.
REQ-003 Parameter TIMEOUT, default 16: maximum ACCESS cycles with pready low before an abort; legal range 2..255.
REQ-004 pclk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 preset  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  2  bit i: requester i has a pending transfer; held high until req_grant[i] is seen.
REQ-007 req_write  in  2  bit i: 1 = write, 0 = read, for requester i.
REQ-008 req_addr  in  2*ADDR_WIDTH  slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]: address for requester i.
REQ-009 req_wdata  in  2*DATA_WIDTH  slice i = [i*DATA_WIDTH +: DATA_WIDTH]: write data for requester i.
REQ-010 req_grant  out  2  one-cycle pulse: requester i's request was latched.
REQ-011 rsp_valid  out  2  one-cycle pulse: requester i's transfer finished.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; qualified by rsp_valid.
REQ-013 rsp_err  out  1  1 = transfer aborted by timeout; qualified by rsp_valid.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 paddr, psel, penable, pwrite, pwdata  out  ADDR_WIDTH/1/1/1/DATA_WIDTH  APB master request signals.
REQ-016 pready, prdata  in  1/DATA_WIDTH  APB completer response signals.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, SETUP and ACCESS, and all outputs SHALL be registered.
REQ-018 IDLE, any req_valid high at an edge: pick winner i, latch req_addr/req_wdata/req_write slice i, go to SETUP; next cycle psel=1, penable=0, req_grant[i]=1.
REQ-019 Arbitration SHALL be round-robin: single requester valid -> that requester wins; both valid -> the requester not granted last wins; the last-granted pointer updates on each grant.
REQ-020 SETUP SHALL last exactly one cycle, then go to ACCESS with psel=1, penable=1.
REQ-021 paddr, pwrite and pwdata SHALL hold the latched values from SETUP until the cycle after completion; pwdata SHALL be 0 for reads.
REQ-022 ACCESS with pready=1: next cycle psel=0, penable=0, rsp_valid[i]=1, rsp_err=0, rsp_rdata=prdata for reads or 0 for writes; go to IDLE.
REQ-023 Timeout counter: clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
REQ-024 When the counter reaches TIMEOUT, the transfer SHALL abort: next cycle psel=0, penable=0, rsp_valid[i]=1, rsp_err=1, rsp_rdata=0; go to IDLE.
REQ-025 If pready=1 in the same cycle the counter would reach TIMEOUT, normal completion (REQ-022) SHALL take priority.
REQ-026 req_valid, req_* inputs SHALL be ignored outside IDLE; a valid still high in the req_grant cycle SHALL NOT create a second request.
REQ-027 Back-to-back throughput SHALL be one transfer per 3 cycles: the IDLE cycle carrying rsp_valid may sample and win a new request.
REQ-028 req_grant and rsp_valid SHALL each be one-hot or zero; pulses SHALL last exactly one cycle.
REQ-029 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid.

Reset
REQ-030 preset=1 at an edge SHALL force IDLE, and the next cycle SHALL show psel, penable, pwrite, busy, req_grant, rsp_valid, rsp_err = 0, paddr, pwdata, rsp_rdata = 0, timeout counter = 0, last-granted pointer = 1 (requester 0 wins first tie).
REQ-031 Reset during SETUP or ACCESS SHALL drop psel/penable in the next cycle and SHALL NOT produce rsp_valid for the abandoned transfer.

Verification
REQ-032 Single read: req_valid=01, addr0=0x10, pready=1 in the first ACCESS cycle, prdata=0xCAFE0001 -> grant=01 at T+1, psel at T+1..T+2, penable at T+2, rsp_valid=01 at T+3, rsp_rdata=0xCAFE0001, rsp_err=0.
REQ-033 Tie fairness: both valid continuously for 4 transfers after reset -> grant order 0,1,0,1; grants 3 cycles apart.
REQ-034 Wait states: write with wdata=0x55AA, pready low 3 ACCESS cycles then high -> penable high 4 cycles; pwdata/paddr stable throughout; rsp_valid one cycle later with rsp_err=0, rsp_rdata=0.
REQ-035 Timeout: TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_rdata=0; the next request proceeds normally.
REQ-036 Boundary: pready=1 on the 4th ACCESS cycle with TIMEOUT=4 -> rsp_err=0.
REQ-037 Reset mid-ACCESS: preset pulsed while penable=1 -> psel=penable=0 next cycle, no rsp_valid, and the first tie afterwards goes to requester 0.
